// File: rtl/memory_access_pkg.sv
// Shared memory-access definitions: op/size encodings, FSM state codes, captured-instruction record.
// Used by memory_access and load_extend.
package memory_access_pkg;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [2:0] MEM_SEL_B  = 3'b000;
    localparam logic [2:0] MEM_SEL_H  = 3'b001;
    localparam logic [2:0] MEM_SEL_W  = 3'b010;
    localparam logic [2:0] MEM_SEL_BU = 3'b100;
    localparam logic [2:0] MEM_SEL_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_WAIT_R = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [1:0]  mem_op;
        logic [2:0]  mem_sel;
        logic [1:0]  wb_sel;
        logic [4:0]  rd;
        logic        reg_we;
        logic [31:0] pc_next;
        logic [31:0] pc_adder_result;
    } instr_t;

    // Byte sizes never trap; unknown size codes behave as word accesses.
    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] a);
        case (sel)
            MEM_SEL_B, MEM_SEL_BU: is_misaligned = 1'b0;
            MEM_SEL_H, MEM_SEL_HU: is_misaligned = a[0];
            default:               is_misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/memory_access_load_extend.sv
// Load data lane extraction and sign/zero extension for byte, half and word loads.
module load_extend
    import memory_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  mem_sel,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = rdata >> {a, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = a[1] ? rdata[31:16] : rdata[15:0];
        case (mem_sel)
            MEM_SEL_B:  data = {{24{byte_v[7]}}, byte_v};
            MEM_SEL_BU: data = {24'h0, byte_v};
            MEM_SEL_H:  data = {{16{half_v[15]}}, half_v};
            MEM_SEL_HU: data = {16'h0, half_v};
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: registers execute outputs, runs req/gnt/rvalid bus transactions.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and flag 'misaligned'.
//
// state     | meaning
// ST_IDLE   | no instruction held, ready to capture
// ST_REQ    | bus request raised, waiting for dmem_gnt
// ST_WAIT_R | load granted, waiting for dmem_rvalid
// ST_DONE   | result presented (out_valid), may capture next
module memory_access
    import memory_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       rs2_data,
    input  logic [1:0]        mem_op,
    input  logic [2:0]        mem_sel,
    input  logic [1:0]        wb_sel,
    input  logic [4:0]        rd,
    input  logic              reg_we,
    input  logic [31:0]       pc_next,
    input  logic [31:0]       pc_adder_result,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misaligned,
`endif
    output logic              out_valid,
    output logic [31:0]       out_alu_result,
    output logic [31:0]       out_load_data,
    output logic [1:0]        out_wb_sel,
    output logic [4:0]        out_rd,
    output logic              out_reg_we,
    output logic [31:0]       out_pc_next,
    output logic [31:0]       out_pc_adder_result
);

    logic [1:0]  state, state_nxt;
    instr_t      q;
    logic [31:0] load_data_q;
    logic        trap_q;
    logic        capture;
    logic        is_mem_in;
    logic        mis_in;
    logic [1:0]  capture_dst;
    logic [1:0]  a;
    logic [31:0] ext_data;
    logic [3:0]  strb_raw;
    logic [31:0] wdata_raw;

    // in_ready is held low while rst is asserted so every output reads 0 in reset.
    assign in_ready  = ~rst & ((state == ST_IDLE) | (state == ST_DONE));
    assign capture   = in_valid & in_ready;
    assign is_mem_in = (mem_op == MEM_OP_LOAD) | (mem_op == MEM_OP_STORE);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_in = is_mem_in & is_misaligned(mem_sel, alu_result[1:0]);
`else
    assign mis_in = 1'b0;
`endif

    assign capture_dst = (is_mem_in & ~mis_in) ? ST_REQ : ST_DONE;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (capture) state_nxt = capture_dst;
            ST_REQ:    if (dmem_gnt) state_nxt = (q.mem_op == MEM_OP_STORE) ? ST_DONE : ST_WAIT_R;
            ST_WAIT_R: if (dmem_rvalid) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = capture ? capture_dst : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            q           <= '0;
            load_data_q <= 32'h0;
            trap_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                q.alu_result      <= alu_result;
                q.rs2_data        <= rs2_data;
                q.mem_op          <= mem_op;
                q.mem_sel         <= mem_sel;
                q.wb_sel          <= wb_sel;
                q.rd              <= rd;
                q.reg_we          <= reg_we;
                q.pc_next         <= pc_next;
                q.pc_adder_result <= pc_adder_result;
                trap_q            <= mis_in;
                load_data_q       <= 32'h0;
            end else if (state == ST_WAIT_R && dmem_rvalid) begin
                load_data_q <= ext_data;
            end
        end
    end

    assign a = q.alu_result[1:0];

    load_extend u_load_extend (
        .rdata   (dmem_rdata),
        .a       (a),
        .mem_sel (q.mem_sel),
        .data    (ext_data)
    );

    // Sub-word stores replicate data across lanes; strobes select the addressed bytes.
    always_comb begin
        case (q.mem_sel)
            MEM_SEL_B, MEM_SEL_BU: begin
                strb_raw  = 4'b0001 << a;
                wdata_raw = {4{q.rs2_data[7:0]}};
            end
            MEM_SEL_H, MEM_SEL_HU: begin
                strb_raw  = a[1] ? 4'b1100 : 4'b0011;
                wdata_raw = {2{q.rs2_data[15:0]}};
            end
            default: begin
                strb_raw  = 4'b1111;
                wdata_raw = q.rs2_data;
            end
        endcase
    end

    assign dmem_req   = (state == ST_REQ);
    assign dmem_we    = dmem_req & (q.mem_op == MEM_OP_STORE);
    assign dmem_addr  = dmem_req ? {q.alu_result[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wstrb = dmem_we ? strb_raw : 4'b0000;
    assign dmem_wdata = dmem_we ? wdata_raw : 32'h0;

    assign out_valid           = (state == ST_DONE);
    assign out_alu_result      = q.alu_result;
    assign out_load_data       = load_data_q;
    assign out_wb_sel          = q.wb_sel;
    assign out_rd              = q.rd;
    assign out_reg_we          = q.reg_we & ~trap_q;
    assign out_pc_next         = q.pc_next;
    assign out_pc_adder_result = q.pc_adder_result;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = trap_q & out_valid;
`endif

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the execute outputs and performs the load/store on a req/gnt/rvalid data-memory bus.
- Byte-aligns and sign/zero-extends load data, then presents one result per instruction to writeback.
- Back-pressures execute via in_ready while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width; alu_result[ADDR_W-1:0] is the byte address.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  execute holds a valid instruction
- in_ready  out  1  stage accepts; capture on in_valid & in_ready
- alu_result  in  32  address for mem ops, else result
- rs2_data  in  32  store data
- mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none
- mem_sel  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (others treated as W)
- wb_sel  in  2  writeback mux select, passthrough
- rd  in  5  destination register
- reg_we  in  1  register write enable
- pc_next  in  32  passthrough
- pc_adder_result  in  32  passthrough (link value)
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- out_valid  out  1  result valid for writeback, one-cycle pulse
- out_alu_result  out  32  captured alu_result
- out_load_data  out  32  extended load data (0 if not a load)
- out_wb_sel, out_rd, out_reg_we, out_pc_next, out_pc_adder_result  out  2/5/1/32/32  captured passthroughs

Behaviour:
- Clocking/reset: one clock clk; reset rst asynchronous, active-high.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - in_ready = 1 after reset is released.
- States: IDLE, REQ, WAIT_R, DONE.
- in_ready = (state==IDLE) | (state==DONE).
- Capture on in_valid & in_ready: latch all inputs.
  - Next state is REQ for load/store, else DONE.
- REQ:
  - dmem_req=1; addr/we/wdata/wstrb stable until dmem_gnt.
  - On gnt: store -> DONE; load -> WAIT_R.
  - req drops the cycle after gnt.
- WAIT_R: on dmem_rvalid, register extended data -> DONE.
  - rvalid in the gnt cycle itself is ignored; the bus guarantees rvalid at least one cycle after gnt.
- DONE:
  - out_valid=1 for exactly one cycle.
  - Without a new capture -> IDLE; with a capture, branch as above (back-to-back).
- Latency (capture in cycle N):
  - Non-mem: out_valid at N+1.
  - Store with gnt at N+1: out_valid at N+2.
  - Load with gnt at N+1 and rvalid at N+2: out_valid at N+3.
  - Each gnt/rvalid wait cycle adds one cycle.
- Store lanes, with a = addr[1:0]:
  - B: wstrb = 1<<a; wdata = {4{rs2[7:0]}}.
  - H: wstrb = 0011<<(a[1]*2); wdata = {2{rs2[15:0]}}.
  - W: wstrb = 1111; wdata = rs2.
- Load extract:
  - B/BU: byte at lane a.
  - H/HU: half at a[1].
  - Sign-extend for B/H; zero-extend for BU/HU.
- Misalignment: without feature, a[0] is ignored for H and a[1:0] is ignored for W.
- No writeback back-pressure; out_* hold their values until the next capture.
- Reset mid-transaction: dmem_req drops immediately (async); late gnt/rvalid after reset is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - H with a[0]=1, or W with a!=0, issues no bus request.
  - State goes straight to DONE.
  - Extra output misaligned (1 bit) is 1 alongside out_valid; out_reg_we forced 0.
- Undefined: port absent; access is silently aligned as described above.

Decomposition:
- Shared header/package mem_defs: MEM_OP_NONE/LOAD/STORE, MEM_SEL_B/H/W/BU/HU, state encodings.
- One sub-module, load_extend (combinational): rdata, a, mem_sel -> 32-bit extended data.
- Store lane/strobe generation stays inline.

Test Plan:
- ALU op (mem_op=00, alu_result=0x12345678, rd=5): out_valid at N+1 with out_alu_result=0x12345678, out_rd=5, out_load_data=0, no dmem_req.
- SB rs2=0xAABBCCDD to addr 0x1003, gnt after 2 wait cycles: dmem_addr=0x1000, wstrb=1000, wdata=0xDDDDDDDD held 3 cycles; out_valid 1 cycle after gnt.
- LH/LHU at 0x2002, rdata=0x8000_1234: LH -> 0xFFFF8000, LHU -> 0x00008000; LB at 0x2001 rdata=0x0000_8000 -> 0xFFFFFF80.
- Back-to-back ALU, LW, ALU with in_valid held high: in_ready low during REQ/WAIT_R; exactly three out_valid pulses, in order.
- rst asserted in WAIT_R, then rvalid: req/out_valid 0 immediately; no out_valid after release; next ALU op completes normally.
- MEM_MISALIGN_TRAP_EN, LW at 0x3002: no dmem_req; out_valid and misaligned at N+1; out_reg_we=0.
